// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_I = 2'd0,
        OWN_D = 2'd1,
        OWN_X = 2'd2
    } owner_t;

    typedef struct packed {
        owner_t owner;
        logic   is_read;
    } tag_t;

    localparam logic [1:0] SIZE_WORD    = 2'd2;
    localparam int         STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// rtl/mem_arb_tag_fifo.sv - in-order FIFO of outstanding memory command tags
// Ports: clk, resetn (sync, active-low); push/push_tag enqueue; pop dequeues;
//        head is the oldest tag; full/empty/count report occupancy.
module mem_arb_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  tag_t                       push_tag,
    input  logic                       pop,
    output tag_t                       head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    tag_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_tag;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - three-way fixed-priority memory port arbiter with starvation promotion
// Ports: i_* fetch, d_* data, x_* DMA command/response channels; m_* memory port;
//        busy = commands outstanding; err_orphan = sticky unmatched memory response.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH       = 13,
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_cmd_valid,
    output logic        i_cmd_ready,
    input  logic [31:0] i_cmd_addr,
    output logic        i_rsp_valid,
    output logic [31:0] i_rsp_data,
    input  logic        d_cmd_valid,
    output logic        d_cmd_ready,
    input  logic        d_cmd_wr,
    input  logic [1:0]  d_cmd_size,
    input  logic [31:0] d_cmd_addr,
    input  logic [31:0] d_cmd_data,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    input  logic        x_cmd_valid,
    output logic        x_cmd_ready,
    input  logic        x_cmd_wr,
    input  logic [31:0] x_cmd_addr,
    input  logic [31:0] x_cmd_data,
    output logic        x_rsp_valid,
    output logic [31:0] x_rsp_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_we,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_data,
    input  logic        m_rsp_valid,
    input  logic [31:0] m_rsp_data,
    output logic        busy,
    output logic        err_orphan
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
    end
    if (AWIDTH < 1 || AWIDTH > 30) begin : g_bad_awidth
        $error("mem_port_arbiter: AWIDTH must be in 1..30");
    end

    localparam logic [STARVE_CNT_W-1:0] LIMIT   = STARVE_CNT_W'(STARVE_LIMIT);
    localparam logic [STARVE_CNT_W-1:0] CNT_MAX = '1;

    logic                                 flush_q;
    logic                                 err_orphan_q;
    logic [STARVE_CNT_W-1:0]              i_wait_q;
    logic [STARVE_CNT_W-1:0]              x_wait_q;
    logic                                 active;
    logic                                 i_elig, d_elig, x_elig;
    logic                                 gnt_any;
    owner_t                               win;
    logic                                 push, pop, rsp_hit;
    tag_t                                 push_tag, head;
    logic                                 fifo_full, fifo_empty;
    logic [$clog2(OUTSTANDING+1)-1:0]     fifo_count;

    // Nothing is granted or retired while in reset or in the flush cycle, so a
    // response to a command issued before reset can never reach a requester.
    assign active = reset & ~flush_q;
    assign i_elig = active & i_cmd_valid & ~fifo_full;
    assign d_elig = active & d_cmd_valid & ~fifo_full;
    assign x_elig = active & x_cmd_valid & ~fifo_full;

    always_comb begin
        gnt_any = 1'b1;
        win     = OWN_D;
        if (i_elig && i_wait_q >= LIMIT)      win = OWN_I;
        else if (x_elig && x_wait_q >= LIMIT) win = OWN_X;
        else if (d_elig)                      win = OWN_D;
        else if (i_elig)                      win = OWN_I;
        else if (x_elig)                      win = OWN_X;
        else                                  gnt_any = 1'b0;
    end

    always_comb begin
        m_we   = 1'b0;
        m_size = SIZE_WORD;
        m_addr = '0;
        m_data = '0;
        case (win)
            OWN_I: m_addr = i_cmd_addr;
            OWN_D: begin
                m_we   = d_cmd_wr;
                m_size = d_cmd_size;
                m_addr = d_cmd_addr;
                m_data = d_cmd_data;
            end
            OWN_X: begin
                m_we   = x_cmd_wr;
                m_addr = x_cmd_addr;
                m_data = x_cmd_data;
            end
            default: m_addr = '0;
        endcase
    end

    assign m_valid     = gnt_any;
    assign i_cmd_ready = gnt_any & (win == OWN_I) & m_ready;
    assign d_cmd_ready = gnt_any & (win == OWN_D) & m_ready;
    assign x_cmd_ready = gnt_any & (win == OWN_X) & m_ready;

    assign push     = gnt_any & m_ready;
    assign push_tag = '{owner: win, is_read: ~m_we};
    assign pop      = active & m_rsp_valid;

    mem_arb_tag_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_tag_fifo (
        .clk      (clk),
        .resetn   (reset),
        .push     (push),
        .push_tag (push_tag),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Write responses pop the FIFO but are never forwarded.
    assign rsp_hit     = pop & ~fifo_empty & head.is_read;
    assign i_rsp_valid = rsp_hit & (head.owner == OWN_I);
    assign d_rsp_valid = rsp_hit & (head.owner == OWN_D);
    assign x_rsp_valid = rsp_hit & (head.owner == OWN_X);
    assign i_rsp_data  = m_rsp_data;
    assign d_rsp_data  = m_rsp_data;
    assign x_rsp_data  = m_rsp_data;

    assign busy       = (fifo_count != '0);
    assign err_orphan = err_orphan_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            flush_q      <= 1'b1;
            err_orphan_q <= 1'b0;
            i_wait_q     <= '0;
            x_wait_q     <= '0;
        end else begin
            flush_q <= 1'b0;
            if (pop && fifo_empty) err_orphan_q <= 1'b1;

            if (!i_cmd_valid || i_cmd_ready)   i_wait_q <= '0;
            else if (i_wait_q != CNT_MAX)      i_wait_q <= i_wait_q + 1'b1;

            if (!x_cmd_valid || x_cmd_ready)   x_wait_q <= '0;
            else if (x_wait_q != CNT_MAX)      x_wait_q <= x_wait_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        i_cmd_valid, i_cmd_ready, i_rsp_valid;
    logic [31:0] i_cmd_addr, i_rsp_data;
    logic        d_cmd_valid, d_cmd_ready, d_cmd_wr, d_rsp_valid;
    logic [1:0]  d_cmd_size;
    logic [31:0] d_cmd_addr, d_cmd_data, d_rsp_data;
    logic        x_cmd_valid, x_cmd_ready, x_cmd_wr, x_rsp_valid;
    logic [31:0] x_cmd_addr, x_cmd_data, x_rsp_data;
    logic        m_valid, m_ready, m_we, m_rsp_valid;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_data, m_rsp_data;
    logic        busy, err_orphan;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:1023];
    logic [31:0] rsp_q [$];
    logic        mdl_rsp_valid;
    logic [31:0] mdl_rsp_data;
    logic        hold;
    logic        inj_valid;
    logic [31:0] inj_data;

    mem_port_arbiter #(
        .AWIDTH       (13),
        .OUTSTANDING  (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd_ready (i_cmd_ready),
        .i_cmd_addr  (i_cmd_addr),
        .i_rsp_valid (i_rsp_valid),
        .i_rsp_data  (i_rsp_data),
        .d_cmd_valid (d_cmd_valid),
        .d_cmd_ready (d_cmd_ready),
        .d_cmd_wr    (d_cmd_wr),
        .d_cmd_size  (d_cmd_size),
        .d_cmd_addr  (d_cmd_addr),
        .d_cmd_data  (d_cmd_data),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_data  (d_rsp_data),
        .x_cmd_valid (x_cmd_valid),
        .x_cmd_ready (x_cmd_ready),
        .x_cmd_wr    (x_cmd_wr),
        .x_cmd_addr  (x_cmd_addr),
        .x_cmd_data  (x_cmd_data),
        .x_rsp_valid (x_rsp_valid),
        .x_rsp_data  (x_rsp_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_we        (m_we),
        .m_size      (m_size),
        .m_addr      (m_addr),
        .m_data      (m_data),
        .m_rsp_valid (m_rsp_valid),
        .m_rsp_data  (m_rsp_data),
        .busy        (busy),
        .err_orphan  (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency memory; responses can be held back to fill the tag FIFO.
    always @(posedge clk) begin
        if (!reset) begin
            mdl_rsp_valid <= 1'b0;
            mdl_rsp_data  <= 32'h0;
            rsp_q.delete();
            for (int k = 0; k < 1024; k++) mem[k] <= 32'hA000_0000 + k;
        end else begin
            if (m_valid && m_ready) begin
                if (m_we) begin
                    mem[m_addr[11:2]] <= m_data;
                    rsp_q.push_back(32'h0);
                end else begin
                    rsp_q.push_back(mem[m_addr[11:2]]);
                end
            end
            if (!hold && rsp_q.size() > 0) begin
                mdl_rsp_valid <= 1'b1;
                mdl_rsp_data  <= rsp_q.pop_front();
            end else begin
                mdl_rsp_valid <= 1'b0;
            end
        end
    end

    assign m_rsp_valid = mdl_rsp_valid | inj_valid;
    assign m_rsp_data  = inj_valid ? inj_data : mdl_rsp_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_cmd_valid = 1'b0;
        d_cmd_valid = 1'b0;
        x_cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; hold = 1'b0; inj_valid = 1'b0; inj_data = 32'h0;
        m_ready = 1'b1;
        i_cmd_valid = 1'b1; i_cmd_addr = 32'h0;
        d_cmd_valid = 1'b1; d_cmd_wr = 1'b0; d_cmd_size = 2'd2;
        d_cmd_addr = 32'h0; d_cmd_data = 32'h0;
        x_cmd_valid = 1'b1; x_cmd_wr = 1'b0; x_cmd_addr = 32'h0; x_cmd_data = 32'h0;

        // Reset held three cycles with all requesters valid.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check("rst_outs", {i_cmd_ready, d_cmd_ready, x_cmd_ready, m_valid,
                               i_rsp_valid, d_rsp_valid, x_rsp_valid}, 32'h0);
            check("rst_busy_err", {busy, err_orphan}, 32'h0);
        end
        @(negedge clk); reset = 1'b1; #1;
        check("flush_outs", {i_cmd_ready, d_cmd_ready, x_cmd_ready, m_valid,
                             i_rsp_valid, d_rsp_valid, x_rsp_valid}, 32'h0);
        @(negedge clk); #1;
        check("first_grant", {i_cmd_ready, d_cmd_ready, x_cmd_ready, m_valid}, 32'b0101);
        check("first_addr", m_addr, 32'h0);
        @(negedge clk); idle(); #1;
        check("first_rsp", {i_rsp_valid, d_rsp_valid, x_rsp_valid}, 32'b010);
        check("first_rsp_data", d_rsp_data, 32'hA000_0000);
        check("first_busy", busy, 32'h1);

        // d and i together: d first, i next, responses in order.
        @(negedge clk);
        d_cmd_valid = 1'b1; d_cmd_addr = 32'h100;
        i_cmd_valid = 1'b1; i_cmd_addr = 32'h200; #1;
        check("di_c1_ready", {i_cmd_ready, d_cmd_ready, x_cmd_ready}, 32'b010);
        check("di_c1_cmd", {m_we, m_size, m_addr}, {1'b0, 2'd2, 32'h100});
        @(negedge clk); d_cmd_valid = 1'b0; #1;
        check("di_c2_ready", {i_cmd_ready, d_cmd_ready, x_cmd_ready}, 32'b100);
        check("di_c2_cmd", {m_we, m_size, m_addr}, {1'b0, 2'd2, 32'h200});
        check("di_c2_rsp", {i_rsp_valid, d_rsp_valid, x_rsp_valid}, 32'b010);
        check("di_c2_data", d_rsp_data, 32'hA000_0040);
        @(negedge clk); i_cmd_valid = 1'b0; #1;
        check("di_c3_rsp", {i_rsp_valid, d_rsp_valid, x_rsp_valid}, 32'b100);
        check("di_c3_data", i_rsp_data, 32'hA000_0080);

        // Starvation: d valid every cycle, x promoted on its fifth waiting cycle.
        @(negedge clk);
        d_cmd_valid = 1'b1; d_cmd_addr = 32'h0;
        x_cmd_valid = 1'b1; x_cmd_wr = 1'b0; x_cmd_addr = 32'h40;
        for (int s = 1; s <= 4; s++) begin
            #1;
            check("starve_wait", {d_cmd_ready, x_cmd_ready}, 32'b10);
            @(negedge clk);
        end
        #1;
        check("starve_promote", {d_cmd_ready, x_cmd_ready}, 32'b01);
        check("starve_addr", m_addr, 32'h40);
        @(negedge clk); #1;
        check("starve_after", {d_cmd_ready, x_cmd_ready}, 32'b10);
        check("starve_cnt_clr", dut.x_wait_q, 32'h0);
        check("starve_rsp", {i_rsp_valid, d_rsp_valid, x_rsp_valid}, 32'b001);
        check("starve_rsp_data", x_rsp_data, 32'hA000_0010);
        @(negedge clk); idle();
        @(negedge clk);

        // Fill the tag FIFO with held responses, then stall the memory.
        hold = 1'b1;
        d_cmd_valid = 1'b1; d_cmd_addr = 32'h100;
        i_cmd_valid = 1'b1; i_cmd_addr = 32'h200; #1;
        check("full_c1", {i_cmd_ready, d_cmd_ready}, 32'b01);
        @(negedge clk); d_cmd_valid = 1'b0; #1;
        check("full_c2", {i_cmd_ready, d_cmd_ready}, 32'b10);
        @(negedge clk);
        i_cmd_valid = 1'b0; m_ready = 1'b0;
        d_cmd_valid = 1'b1; d_cmd_addr = 32'h300;
        for (int f = 0; f < 4; f++) begin
            if (f == 3) hold = 1'b0;
            #1;
            check("full_ready", {i_cmd_ready, d_cmd_ready, x_cmd_ready, m_valid}, 32'h0);
            check("full_busy", busy, 32'h1);
            @(negedge clk);
        end
        m_ready = 1'b1; #1;
        check("pop1_rsp", {i_rsp_valid, d_rsp_valid, x_rsp_valid}, 32'b010);
        check("pop1_data", d_rsp_data, 32'hA000_0040);
        check("pop1_ready", {d_cmd_ready, m_valid}, 32'b00);
        check("pop1_busy", busy, 32'h1);
        @(negedge clk); #1;
        check("pop2_ready", {d_cmd_ready, m_valid}, 32'b11);
        check("pop2_addr", m_addr, 32'h300);
        check("pop2_rsp", {i_rsp_valid, d_rsp_valid, x_rsp_valid}, 32'b100);
        check("pop2_data", i_rsp_data, 32'hA000_0080);
        check("pop2_busy", busy, 32'h1);
        @(negedge clk); d_cmd_valid = 1'b0; #1;
        check("pop3_rsp", {i_rsp_valid, d_rsp_valid, x_rsp_valid}, 32'b010);
        check("pop3_data", d_rsp_data, 32'hA000_00C0);
        @(negedge clk); #1;
        check("drain_busy", busy, 32'h0);

        // x write then read back.
        @(negedge clk);
        x_cmd_valid = 1'b1; x_cmd_wr = 1'b1; x_cmd_addr = 32'h40; x_cmd_data = 32'hDEAD_BEEF; #1;
        check("xw_ready", x_cmd_ready, 32'h1);
        check("xw_cmd", {m_we, m_size, m_addr, m_data}, {1'b1, 2'd2, 32'h40, 32'hDEAD_BEEF});
        @(negedge clk); x_cmd_wr = 1'b0; #1;
        check("xr_ready", x_cmd_ready, 32'h1);
        check("xr_we", m_we, 32'h0);
        check("xw_no_rsp", {i_rsp_valid, d_rsp_valid, x_rsp_valid}, 32'h0);
        @(negedge clk); x_cmd_valid = 1'b0; #1;
        check("xr_rsp", {i_rsp_valid, d_rsp_valid, x_rsp_valid}, 32'b001);
        check("xr_data", x_rsp_data, 32'hDEAD_BEEF);

        // Orphan response with the FIFO empty.
        @(negedge clk); inj_valid = 1'b1; inj_data = 32'h1234_5678; #1;
        check("orph_rsp", {i_rsp_valid, d_rsp_valid, x_rsp_valid}, 32'h0);
        check("orph_pre", err_orphan, 32'h0);
        @(negedge clk); inj_valid = 1'b0; #1;
        check("orph_set", err_orphan, 32'h1);
        for (int o = 0; o < 2; o++) begin
            @(negedge clk); #1;
            check("orph_sticky", err_orphan, 32'h1);
        end
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1; #1;
        check("orph_clr", err_orphan, 32'h0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
